// File: rtl/ycc_pkg.sv
// Shared constants, stage bundles and the output clamp
// for the YCbCr -> RGB inverse colour-space pipeline.
package ycc_pkg;

  localparam int SCALE = 16;
  localparam int ACC_WIDTH = 28;

  localparam int K_RCR = 91881;
  localparam int K_GCB = 22553;
  localparam int K_GCR = 46802;
  localparam int K_BCB = 116130;

  localparam logic signed [8:0] OFFSET_128 = 9'sd128;

  localparam logic signed [ACC_WIDTH-1:0] ROUND =
    ACC_WIDTH'(2 ** (SCALE - 1));

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  typedef enum logic [1:0] {
    C_RCR = 2'd0,
    C_GCB = 2'd1,
    C_GCR = 2'd2,
    C_BCB = 2'd3
  } coef_e;

  typedef struct packed {
    logic [7:0]        y;
    logic signed [8:0] dcb;
    logic signed [8:0] dcr;
    logic              last;
  } s1_t;

  typedef struct packed {
    acc_t ysh;
    acc_t p_rcr;
    acc_t p_gcb;
    acc_t p_gcr;
    acc_t p_bcb;
    logic last;
  } s2_t;

  // Rounded sum in, 8-bit channel out; drop the fraction,
  // then saturate so negative and >255 never wrap.
  function automatic logic [7:0] clamp8(input acc_t v);
    acc_t s;
    s = v >>> SCALE;
    if (s[ACC_WIDTH-1])
      return 8'd0;
    if (|s[ACC_WIDTH-2:8])
      return 8'hff;
    return s[7:0];
  endfunction

endpackage

// File: rtl/ycbcr_to_rgb_pipe_if.sv
// Pixel stream bundle: YCbCr in (s_*), RGB out (m_*).
// slave = converter view, master = source/sink view.
interface ycbcr_to_rgb_pipe_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_y;
  logic [7:0] s_cb;
  logic [7:0] s_cr;
  logic       s_last;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_r;
  logic [7:0] m_g;
  logic [7:0] m_b;
  logic       m_last;

  modport master (
    output s_valid, s_y, s_cb, s_cr, s_last, m_ready,
    input  s_ready, m_valid, m_r, m_g, m_b, m_last
  );

  modport slave (
    input  s_valid, s_y, s_cb, s_cr, s_last, m_ready,
    output s_ready, m_valid, m_r, m_g, m_b, m_last
  );
endinterface

// File: rtl/ycc2rgb_csd_mult.sv
// Multiplierless K*d: signed 9-bit d times a selected
// coefficient, as canonic-signed-digit shift-adds.
module ycc2rgb_csd_mult
  import ycc_pkg::*;
(
  input  logic signed [8:0] d,
  input  coef_e             sel,
  output acc_t              p
);

  acc_t x;
  assign x = ACC_WIDTH'(d);

  always_comb begin
    p = '0;
    unique case (sel)
      C_RCR: p = (x <<< 16) + (x <<< 15)
               - (x <<< 13) + (x <<< 11)
               - (x <<< 9)  + (x <<< 8)
               - (x <<< 5)  + (x <<< 3)
               + x;
      C_GCB: p = (x <<< 14) + (x <<< 13)
               - (x <<< 11) + (x <<< 5)
               - (x <<< 3)  + x;
      C_GCR: p = (x <<< 15) + (x <<< 14)
               - (x <<< 12) + (x <<< 11)
               - (x <<< 9)  + (x <<< 8)
               - (x <<< 6)  + (x <<< 4)
               + (x <<< 1);
      C_BCB: p = (x <<< 17) - (x <<< 14)
               + (x <<< 10) + (x <<< 9)
               - (x <<< 7)  + (x <<< 5)
               + (x <<< 1);
      default: p = '0;
    endcase
  end

endmodule

// File: rtl/ycbcr_to_rgb_pipe.sv
// 3-stage YCbCr -> RGB converter, one pixel per clock,
// global stall on output backpressure; ports via bus.
module ycbcr_to_rgb_pipe
  import ycc_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  ycbcr_to_rgb_pipe_if.slave bus
);

  logic adv;
  logic v1;
  logic v2;
  s1_t  s1_q;
  s2_t  s2_q;
  acc_t p_rcr;
  acc_t p_gcb;
  acc_t p_gcr;
  acc_t p_bcb;
  acc_t r_sum;
  acc_t g_sum;
  acc_t b_sum;

  // Whole pipe moves only when the output slot frees up.
  assign adv = ~bus.m_valid | bus.m_ready;
  assign bus.s_ready = adv;

  ycc2rgb_csd_mult u_rcr (
    .d(s1_q.dcr), .sel(C_RCR), .p(p_rcr)
  );
  ycc2rgb_csd_mult u_gcb (
    .d(s1_q.dcb), .sel(C_GCB), .p(p_gcb)
  );
  ycc2rgb_csd_mult u_gcr (
    .d(s1_q.dcr), .sel(C_GCR), .p(p_gcr)
  );
  ycc2rgb_csd_mult u_bcb (
    .d(s1_q.dcb), .sel(C_BCB), .p(p_bcb)
  );

  always_comb begin
    r_sum = s2_q.ysh + s2_q.p_rcr + ROUND;
    g_sum = s2_q.ysh - s2_q.p_gcb
          - s2_q.p_gcr + ROUND;
    b_sum = s2_q.ysh + s2_q.p_bcb + ROUND;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
      bus.m_valid <= 1'b0;
      bus.m_r     <= 8'd0;
      bus.m_g     <= 8'd0;
      bus.m_b     <= 8'd0;
      bus.m_last  <= 1'b0;
    end else if (adv) begin
      v1 <= bus.s_valid;
      if (bus.s_valid) begin
        s1_q.y    <= bus.s_y;
        s1_q.dcb  <= $signed({1'b0, bus.s_cb})
                     - OFFSET_128;
        s1_q.dcr  <= $signed({1'b0, bus.s_cr})
                     - OFFSET_128;
        s1_q.last <= bus.s_last;
      end
      v2 <= v1;
      if (v1) begin
        s2_q.ysh   <= ACC_WIDTH'({s1_q.y,
                                  {SCALE{1'b0}}});
        s2_q.p_rcr <= p_rcr;
        s2_q.p_gcb <= p_gcb;
        s2_q.p_gcr <= p_gcr;
        s2_q.p_bcb <= p_bcb;
        s2_q.last  <= s1_q.last;
      end
      bus.m_valid <= v2;
      if (v2) begin
        bus.m_r    <= clamp8(r_sum);
        bus.m_g    <= clamp8(g_sum);
        bus.m_b    <= clamp8(b_sum);
        bus.m_last <= s2_q.last;
      end
    end
  end

endmodule

// File: tb/tb_ycbcr_to_rgb_pipe.sv
// Directed-vector and scoreboard bench for
// ycbcr_to_rgb_pipe: colour math, latency, stalls, reset.
module tb_ycbcr_to_rgb_pipe;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  ycbcr_to_rgb_pipe_if bus ();

  ycbcr_to_rgb_pipe dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] y, cb, cr;
    logic [7:0] r, g, b;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               name, act, exp);
    end
  endtask

  function automatic longint clip(input longint v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  // Golden model: {r, g, b, last} using plain multiplies.
  function automatic logic [24:0] model(
    input logic [7:0] y, cb, cr, input logic last);
    longint ys, dcb, dcr, r, g, b;
    ys  = longint'(y) * 65536;
    dcb = longint'(cb) - 128;
    dcr = longint'(cr) - 128;
    r = clip((ys + 91881 * dcr + 32768) >>> 16);
    g = clip((ys - 22553 * dcb - 46802 * dcr
              + 32768) >>> 16);
    b = clip((ys + 116130 * dcb + 32768) >>> 16);
    return {r[7:0], g[7:0], b[7:0], last};
  endfunction

  function automatic logic [24:0] outs();
    return {bus.m_r, bus.m_g, bus.m_b, bus.m_last};
  endfunction

  task automatic drive(input logic [7:0] y, cb, cr,
                       input logic last);
    bus.s_valid = 1'b1;
    bus.s_y     = y;
    bus.s_cb    = cb;
    bus.s_cr    = cr;
    bus.s_last  = last;
  endtask

  // Send one pixel with m_ready high; check 3-cycle latency.
  task automatic single(input string nm,
                        input logic [7:0] y, cb, cr,
                        input logic last,
                        input logic [23:0] rgb);
    @(negedge clk);
    bus.m_ready = 1'b1;
    drive(y, cb, cr, last);
    chk({nm, "_s_ready"}, 32'(bus.s_ready), 32'd1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_early"}, 32'(bus.m_valid), 32'd0);
    @(negedge clk);
    chk({nm, "_valid"}, 32'(bus.m_valid), 32'd1);
    chk({nm, "_rgb"}, 32'(outs()), 32'({rgb, last}));
  endtask

  initial begin
    logic [24:0] q[$];
    logic [24:0] e;
    logic [24:0] held;
    logic        held_v;
    logic        pend;
    int          sent, rcvd, cyc;
    logic        seen;

    n_tests = 0;
    n_fail  = 0;
    tbl[0] = '{8'd128, 8'd128, 8'd128,
               8'd128, 8'd128, 8'd128};
    tbl[1] = '{8'd255, 8'd255, 8'd128,
               8'd255, 8'd211, 8'd255};
    tbl[2] = '{8'd0, 8'd0, 8'd0,
               8'd0, 8'd135, 8'd0};
    tbl[3] = '{8'd0, 8'd128, 8'd255,
               8'd178, 8'd0, 8'd0};
    tbl[4] = '{8'd100, 8'd128, 8'd200,
               8'd201, 8'd49, 8'd100};
    tbl[5] = '{8'd16, 8'd128, 8'd128,
               8'd16, 8'd16, 8'd16};

    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_y     = 8'd0;
    bus.s_cb    = 8'd0;
    bus.s_cr    = 8'd0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_outs", 32'(outs()), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd1);

    for (int i = 0; i < 6; i++)
      single($sformatf("vec%0d", i),
             tbl[i].y, tbl[i].cb, tbl[i].cr, i[0],
             {tbl[i].r, tbl[i].g, tbl[i].b});

    // Random stream with gaps and random backpressure.
    sent = 0; rcvd = 0; cyc = 0;
    held_v = 1'b0; pend = 1'b0; held = '0;
    while (rcvd < 16 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (held_v)
        chk("stall_stable",
            32'({bus.m_valid, outs()}),
            32'({1'b1, held}));
      bus.m_ready = ($urandom_range(0, 3) != 0);
      if (!pend) begin
        if (sent < 16 && $urandom_range(0, 3) != 0)
          drive(8'($urandom), 8'($urandom),
                8'($urandom), 1'($urandom));
        else
          bus.s_valid = 1'b0;
      end
      #1;
      pend = bus.s_valid & ~bus.s_ready;
      if (bus.s_valid & bus.s_ready) begin
        q.push_back(model(bus.s_y, bus.s_cb,
                          bus.s_cr, bus.s_last));
        sent++;
      end
      if (bus.m_valid & bus.m_ready) begin
        if (q.size() == 0) begin
          chk("stream_extra", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk($sformatf("stream_px%0d", rcvd),
              32'(outs()), 32'(e));
        end
        rcvd++;
      end
      held_v = bus.m_valid & ~bus.m_ready;
      held   = outs();
    end
    chk("stream_done", 32'(rcvd), 32'd16);
    chk("stream_sb_empty", 32'(q.size()), 32'd0);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Fill three pixels, stall output five cycles.
    bus.m_ready = 1'b0;
    drive(8'd128, 8'd128, 8'd128, 1'b0);
    @(negedge clk);
    drive(8'd255, 8'd255, 8'd128, 1'b1);
    @(negedge clk);
    drive(8'd0, 8'd128, 8'd255, 1'b0);
    @(negedge clk);
    bus.s_valid = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.s_ready | ~bus.m_valid) seen = 1'b1;
    end
    chk("fill_stalled", 32'(seen), 32'd0);
    chk("fill_head", 32'(outs()),
        32'(model(8'd128, 8'd128, 8'd128, 1'b0)));
    bus.m_ready = 1'b1;
    #1;
    chk("fill_s_ready", 32'(bus.s_ready), 32'd1);
    @(negedge clk);
    chk("drain_px1", 32'({bus.m_valid, outs()}),
        32'({1'b1, model(8'd255, 8'd255,
                         8'd128, 1'b1)}));
    @(negedge clk);
    chk("drain_px2", 32'({bus.m_valid, outs()}),
        32'({1'b1, model(8'd0, 8'd128,
                         8'd255, 1'b0)}));
    @(negedge clk);
    chk("drain_empty", 32'(bus.m_valid), 32'd0);

    // Reset with two pixels in flight.
    bus.m_ready = 1'b0;
    drive(8'd200, 8'd60, 8'd90, 1'b1);
    @(negedge clk);
    drive(8'd30, 8'd220, 8'd40, 1'b0);
    @(negedge clk);
    bus.s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_valid", 32'(bus.m_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.m_valid), 32'd0);
    chk("async_rst_outs", 32'(outs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.m_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.m_valid) seen = 1'b1;
    end
    chk("no_stale", 32'(seen), 32'd0);
    single("post_rst", 8'd255, 8'd255, 8'd128, 1'b1,
           {8'd255, 8'd211, 8'd255});

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
